// File: rtl/serial_borrow_subtractor_32.sv
// Multi-cycle subtractor: diff = a - b - bin, SLICE bits per clock, LSB slice first.
// Operands shift right through the slice window; the result shifts in from the top.
module serial_borrow_subtractor_32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NS = WIDTH / SLICE;
  localparam int CW = $clog2(NS + 1);
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  generate
    if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("serial_borrow_subtractor_32: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [SLICE:0]         slice_res;
  logic [WIDTH+SLICE-1:0] diff_shift;

  // Borrow out of the slice lands in the MSB of the SLICE+1 bit difference.
  always_comb begin
    slice_res  = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - {{SLICE{1'b0}}, brw_q};
    diff_shift = {slice_res[SLICE-1:0], diff_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d    = a_q >> SLICE;
        b_d    = b_q >> SLICE;
        diff_d = diff_shift[WIDTH+SLICE-1:SLICE];
        brw_d  = slice_res[SLICE];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bout_d  = slice_res[SLICE];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_borrow_subtractor_32.sv
// Bench for serial_borrow_subtractor_32: three instances (SLICE 4, 8, 1) checked every
// cycle against a transaction-level model of the handshake and 33-bit arithmetic.
module tb_serial_borrow_subtractor_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_v    [3];
  logic [31:0] b_v    [3];
  logic        bin_v  [3];
  logic        iv_v   [3];
  logic        or_v   [3];
  logic        ir_v   [3];
  logic [31:0] diff_v [3];
  logic        bout_v [3];
  logic        ov_v   [3];

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int SL = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
    serial_borrow_subtractor_32 #(.WIDTH(32), .SLICE(SL)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .bin       (bin_v[g]),
      .in_valid  (iv_v[g]),
      .in_ready  (ir_v[g]),
      .diff      (diff_v[g]),
      .bout      (bout_v[g]),
      .out_valid (ov_v[g]),
      .out_ready (or_v[g])
    );
  end

  function automatic int ns_of(input int l);
    return (l == 0) ? 8 : ((l == 1) ? 4 : 32);
  endfunction

  // Model: idle/busy with cycles-since-accept; result is plain 33-bit arithmetic.
  bit          m_busy [3];
  int          m_age  [3];
  logic [32:0] m_exp  [3];
  logic [32:0] m_last [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 3; l++) begin
        m_busy[l] <= 1'b0;
        m_age[l]  <= 0;
        m_exp[l]  <= '0;
        m_last[l] <= '0;
      end
    end else begin
      for (int l = 0; l < 3; l++) begin
        if (!m_busy[l]) begin
          if (iv_v[l]) begin
            m_busy[l] <= 1'b1;
            m_age[l]  <= 0;
            m_exp[l]  <= {1'b0, a_v[l]} - {1'b0, b_v[l]} - 33'(bin_v[l]);
          end
        end else if (m_age[l] < ns_of(l)) begin
          m_age[l] <= m_age[l] + 1;
          if (m_age[l] + 1 == ns_of(l)) m_last[l] <= m_exp[l];
        end else if (or_v[l]) begin
          m_busy[l] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    for (int l = 0; l < 3; l++) begin
      if (!rst_n) begin
        chk($sformatf("L%0d rst in_ready", l), 64'(ir_v[l]), 64'd0);
        chk($sformatf("L%0d rst out_valid", l), 64'(ov_v[l]), 64'd0);
      end else begin
        chk($sformatf("L%0d in_ready", l), 64'(ir_v[l]), 64'(!m_busy[l]));
        chk($sformatf("L%0d out_valid", l), 64'(ov_v[l]),
            64'(m_busy[l] && m_age[l] == ns_of(l)));
        if (!m_busy[l])
          chk($sformatf("L%0d idle result", l), 64'({bout_v[l], diff_v[l]}), 64'(m_last[l]));
        else if (m_age[l] == ns_of(l))
          chk($sformatf("L%0d result", l), 64'({bout_v[l], diff_v[l]}), 64'(m_exp[l]));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accept edge; waits for out_valid and checks latency and value.
  task automatic wait_result(input string nm, input logic [31:0] ed, input logic eb);
    int c;
    c = 0;
    while (c < 60 && ov_v[0] !== 1'b1) begin
      tick();
      c++;
    end
    chk({nm, " latency"}, 64'(c), 64'd8);
    chk({nm, " diff"}, 64'(diff_v[0]), 64'(ed));
    chk({nm, " bout"}, 64'(bout_v[0]), 64'(eb));
    chk({nm, " model"}, 64'(m_exp[0]), 64'({eb, ed}));
  endtask

  task automatic run_op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                        input logic bi, input logic [31:0] ed, input logic eb);
    chk({nm, " ready before"}, 64'(ir_v[0]), 64'd1);
    a_v[0] = av; b_v[0] = bv; bin_v[0] = bi; iv_v[0] = 1'b1; or_v[0] = 1'b1;
    tick();
    iv_v[0] = 1'b0;
    wait_result(nm, ed, eb);
    tick();
    chk({nm, " ready after"}, 64'(ir_v[0]), 64'd1);
    chk({nm, " valid after"}, 64'(ov_v[0]), 64'd0);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_lane(input int l, input int n);
    int guard;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin
        or_v[l] = ($urandom_range(0, 3) != 0);
        tick();
      end
      a_v[l] = rnd32(); b_v[l] = rnd32(); bin_v[l] = 1'($urandom_range(0, 1));
      iv_v[l] = 1'b1;
      guard = 0;
      while (ir_v[l] !== 1'b1 && guard < 200) begin
        or_v[l] = ($urandom_range(0, 3) != 0);
        tick();
        guard++;
      end
      chk($sformatf("L%0d ready wait bound", l), 64'(guard < 200), 64'd1);
      or_v[l] = ($urandom_range(0, 3) != 0);
      tick();
      iv_v[l] = 1'b0;
    end
    or_v[l] = 1'b1;
    repeat (ns_of(l) + 4) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int l = 0; l < 3; l++) begin
      a_v[l] = '0; b_v[l] = '0; bin_v[l] = 1'b0; iv_v[l] = 1'b0; or_v[l] = 1'b1;
    end
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();
    chk("reset in_ready", 64'(ir_v[0]), 64'd1);
    chk("reset out_valid", 64'(ov_v[0]), 64'd0);
    chk("reset diff", 64'(diff_v[0]), 64'd0);
    chk("reset bout", 64'(bout_v[0]), 64'd0);

    run_op("5-3", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0);
    run_op("0-1", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_op("8000-7fff-1", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0, 1'b0);
    run_op("eq-1", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1);

    // Backpressure: hold the result while a second operand waits.
    a_v[0] = 32'h9; b_v[0] = 32'h4; bin_v[0] = 1'b0; iv_v[0] = 1'b1; or_v[0] = 1'b0;
    tick();
    iv_v[0] = 1'b0;
    wait_result("bp first", 32'h5, 1'b0);
    a_v[0] = 32'h100; b_v[0] = 32'h1; bin_v[0] = 1'b0; iv_v[0] = 1'b1;
    repeat (5) begin
      tick();
      chk("bp out_valid", 64'(ov_v[0]), 64'd1);
      chk("bp in_ready", 64'(ir_v[0]), 64'd0);
      chk("bp held", 64'({bout_v[0], diff_v[0]}), 64'h5);
    end
    or_v[0] = 1'b1;
    tick();
    chk("bp handshake ready", 64'(ir_v[0]), 64'd1);
    chk("bp handshake valid", 64'(ov_v[0]), 64'd0);
    tick();
    chk("bp second accepted", 64'(ir_v[0]), 64'd0);
    iv_v[0] = 1'b0;
    wait_result("bp second", 32'hFF, 1'b0);
    tick();

    // Asynchronous reset in the middle of RUN, between clock edges.
    a_v[0] = 32'hFFFF_0000; b_v[0] = 32'h0000_1234; bin_v[0] = 1'b0; iv_v[0] = 1'b1;
    tick();
    iv_v[0] = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(ov_v[0]), 64'd0);
    chk("async rst diff", 64'(diff_v[0]), 64'd0);
    chk("async rst bout", 64'(bout_v[0]), 64'd0);
    chk("async rst in_ready", 64'(ir_v[0]), 64'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post rst in_ready", 64'(ir_v[0]), 64'd1);
    chk("post rst out_valid", 64'(ov_v[0]), 64'd0);
    run_op("10-1", 32'h10, 32'h1, 1'b0, 32'hF, 1'b0);

    rand_lane(0, 2000);
    rand_lane(1, 1000);
    rand_lane(2, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
